conv_adder_tree_pipe: RTL and testbench



---
 rtl/conv_filter_pkg.sv | 13 +
 rtl/conv_out_sat_round.sv | 28 ++
 rtl/conv_adder_tree_pipe.sv | 64 ++++++
 tb/tb_conv_adder_tree_pipe.sv | 126 ++++++++++++
 4 files changed

// File: rtl/conv_filter_pkg.sv
// conv_filter_pkg: shared widths, clog2 and saturation limits for the spatial filter datapaths
package conv_filter_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int TW = 8 + 15 + 1;
  localparam int LEVELS = clog2(49);
  localparam int SW = TW + LEVELS;
  localparam int SAT_MAX = (1 << 8) - 1;
  localparam int SAT_MIN = -(1 << 8);
endpackage

// File: rtl/conv_out_sat_round.sv
// conv_out_sat_round: shift, optional round-half-up (CONV_ADDER_TREE_ROUND_EN) and saturate a tree sum
module conv_out_sat_round
  import conv_filter_pkg::*;
#(
  parameter int PIX_BIT = 8,
  parameter int SW = 30,
  parameter int OUT_SHIFT = 15
) (
  input  logic signed [SW-1:0]  sum,
  output logic signed [PIX_BIT:0] q_next,
  output logic                  sat_next
);
  localparam logic signed [SW:0] HI = (SW+1)'((1 << PIX_BIT) - 1);
  localparam logic signed [SW:0] LO = ~HI;
  logic signed [SW:0] wide;
  logic signed [SW:0] s;
`ifdef CONV_ADDER_TREE_ROUND_EN
  assign wide = {sum[SW-1], sum} + ((SW+1)'(1) << (OUT_SHIFT - 1));
`else
  assign wide = {sum[SW-1], sum};
`endif
  assign s = wide >>> OUT_SHIFT;
  // clamp the shifted sum into the signed output pixel range
  always_comb begin
    sat_next = (s > HI) || (s < LO);
    q_next = (s > HI) ? HI[PIX_BIT:0] : (s < LO) ? LO[PIX_BIT:0] : s[PIX_BIT:0];
  end
endmodule

// File: rtl/conv_adder_tree_pipe.sv
// conv_adder_tree_pipe: pipelined signed adder tree with ce stall and saturating output (CONV_ADDER_TREE_ROUND_EN selects rounding)
module conv_adder_tree_pipe
  import conv_filter_pkg::*;
#(
  parameter int PIX_BIT = 8,
  parameter int COFCNT_BIT = 15,
  parameter int MASK_WIDTH = 7,
  parameter int TERM_SIZE = MASK_WIDTH ** 2,
  parameter int OUT_SHIFT = 15
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          ce,
  input  logic [(PIX_BIT+COFCNT_BIT+1)*TERM_SIZE-1:0]   term_in,
  input  logic                                          in_valid,
  output logic signed [PIX_BIT:0]                       q,
  output logic                                          out_valid,
  output logic                                          sat
);
  localparam int TWL = PIX_BIT + COFCNT_BIT + 1;
  localparam int LVL = clog2(TERM_SIZE);
  localparam int SWL = TWL + LVL;
  localparam int NP = 1 << LVL;
  logic signed [SWL-1:0] leaf [NP];
  logic signed [SWL-1:0] node [2*NP-1];
  logic [LVL:0] vld;
  logic signed [PIX_BIT:0] q_next;
  logic sat_next;
  for (genvar g = 0; g < NP; g++) begin : g_leaf
    if (g < TERM_SIZE) begin : g_t
      assign leaf[g] = SWL'($signed(term_in[TWL*g +: TWL]));
    end else begin : g_z
      assign leaf[g] = '0;
    end
  end
  // heap-ordered tree: leaves at NP-1.., node i sums children 2i+1/2i+2, root at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2*NP-1; i++) node[i] <= '0;
      vld <= '0;
    end else if (ce) begin
      for (int i = 0; i < NP; i++) node[NP-1+i] <= leaf[i];
      for (int i = 0; i < NP-1; i++) node[i] <= node[2*i+1] + node[2*i+2];
      vld <= {vld[LVL-1:0], in_valid};
    end
  end
  conv_out_sat_round #(.PIX_BIT(PIX_BIT), .SW(SWL), .OUT_SHIFT(OUT_SHIFT)) u_sat (
    .sum(node[0]),
    .q_next(q_next),
    .sat_next(sat_next)
  );
  // output register holds the clamped pixel and its flags
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
      sat <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      q <= q_next;
      sat <= sat_next;
      out_valid <= vld[LVL];
    end
  end
endmodule

// File: tb/tb_conv_adder_tree_pipe.sv
// tb_conv_adder_tree_pipe: directed checks of latency, saturation, rounding, ce stall and reset flush
module tb_conv_adder_tree_pipe;
  localparam int TW = 24;
  localparam int N = 49;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  logic [TW*N-1:0] term_in = '0;
  logic in_valid = 1'b0;
  logic signed [8:0] q;
  logic out_valid;
  logic sat;
  int n_cmp = 0;
  int n_bad = 0;
  conv_adder_tree_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .term_in(term_in),
    .in_valid(in_valid), .q(q), .out_valid(out_valid), .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [TW*N-1:0] fill(input int v);
    logic [TW*N-1:0] r;
    logic [31:0] w;
    w = v;
    for (int i = 0; i < N; i++) r[TW*i +: TW] = w[TW-1:0];
    return r;
  endfunction
  function automatic logic [TW*N-1:0] one(input int idx, input int v);
    logic [TW*N-1:0] r;
    logic [31:0] w;
    r = '0;
    w = v;
    r[TW*idx +: TW] = w[TW-1:0];
    return r;
  endfunction
  task automatic run_one(input string tag, input logic [TW*N-1:0] vec, input int eq, input int es);
    term_in = vec;
    in_valid = 1'b1;
    step();
    term_in = '0;
    in_valid = 1'b0;
    repeat (6) step();
    chk({tag, "_early"}, int'(out_valid), 0);
    step();
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_q"}, int'(q), eq);
    chk({tag, "_sat"}, int'(sat), es);
    step();
    chk({tag, "_drop"}, int'(out_valid), 0);
  endtask
  initial begin
    int got[$];
    int last_edge;
    int idx;
    int stale;
    @(negedge clk);
    step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_sat", int'(sat), 0);
    reset = 1'b0;
    run_one("ones", fill(1 << 15), 49, 0);
    run_one("pos_sat", fill(10 << 15), 255, 1);
    run_one("neg_sat", fill(-(10 << 15)), -256, 1);
    run_one("leftover", one(48, 100 << 15), 100, 0);
`ifdef CONV_ADDER_TREE_ROUND_EN
    run_one("half_pos", one(0, (5 << 15) + (1 << 14)), 6, 0);
    run_one("half_neg", one(0, -(1 << 14)), 0, 0);
`else
    run_one("half_pos", one(0, (5 << 15) + (1 << 14)), 5, 0);
    run_one("half_neg", one(0, -(1 << 14)), -1, 0);
`endif
    idx = 1;
    last_edge = 0;
    for (int e = 1; e <= 24; e++) begin
      ce = !(e >= 6 && e <= 8);
      in_valid = idx <= 10;
      term_in = idx <= 10 ? one(0, idx << 15) : '0;
      step();
      if (ce && idx <= 10) idx++;
      if (ce && out_valid) begin
        got.push_back(int'(q));
        last_edge = e;
      end
    end
    ce = 1'b1;
    in_valid = 1'b0;
    chk("stream_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk($sformatf("stream_%0d", i), got[i], i + 1);
    chk("stream_last_edge", last_edge, 20);
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      term_in = one(0, (20 + j) << 15);
      step();
    end
    in_valid = 1'b0;
    term_in = '0;
    reset = 1'b1;
    ce = 1'b0;
    step();
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_q", int'(q), 0);
    chk("flush_sat", int'(sat), 0);
    reset = 1'b0;
    ce = 1'b1;
    stale = 0;
    repeat (10) begin
      step();
      if (out_valid) stale++;
    end
    chk("flush_stale", stale, 0);
    run_one("post_rst", one(3, 77 << 15), 77, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
